// File: rtl/obd_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : obd_frame_tx
//  Description : Snapshots the vehicle-state inputs and streams them as a
//                fixed telemetry frame, one byte per valid/ready handshake,
//                into a downstream UART byte transmitter. Frames start on a
//                periodic tick count, a manual request, or an ESS rising edge.
//  Options     : OBD_SEQ_EN - inserts a sequence byte after LEN (14-byte frame)
//  Revision    : 1.0 - initial release
// ============================================================================
module obd_frame_tx #(
  parameter int         PERIOD_TICKS = 1,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        engine_on,
  input  logic        tick_1sec,
  input  logic        req,
  input  logic [7:0]  speed,
  input  logic [13:0] rpm,
  input  logic [7:0]  fuel,
  input  logic [7:0]  temp,
  input  logic [31:0] odometer_raw,
  input  logic [3:0]  current_gear,
  input  logic        ess_trigger,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_count
);

`ifdef OBD_SEQ_EN
  localparam int         c_nbytes = 14;
  localparam logic [7:0] c_len    = 8'h0B;
  localparam int         c_off    = 3;   // first payload byte after seq byte
`else
  localparam int         c_nbytes = 13;
  localparam logic [7:0] c_len    = 8'h0A;
  localparam int         c_off    = 2;   // first payload byte after LEN
`endif
  localparam logic [3:0] c_last   = 4'(c_nbytes - 1);
  localparam logic [7:0] c_period = 8'(PERIOD_TICKS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic        r_pending;
  logic [7:0]  r_period_cnt;
  logic        r_ess_d;
  logic [15:0] r_frame_count;

  // frozen copy of the inputs for the frame in flight
  logic [7:0]  r_speed;
  logic [13:0] r_rpm;
  logic [7:0]  r_fuel;
  logic [7:0]  r_temp;
  logic [31:0] r_odo;
  logic [7:0]  r_status;
`ifdef OBD_SEQ_EN
  logic [7:0]  r_seq;
`endif

  logic        w_start;
  logic        w_accept;
  logic        w_last;
  logic [7:0]  w_cnt_inc;
  logic        w_period_hit;
  logic        w_ess_rise;
  logic        w_trig;
  logic [7:0]  w_frame [0:15];
  logic [7:0]  w_chk;

  // trigger sources: periodic tick count, manual request, ESS rising edge
  assign w_cnt_inc    = r_period_cnt + 8'd1;
  assign w_period_hit = tick_1sec && engine_on && (w_cnt_inc == c_period);
  assign w_ess_rise   = ess_trigger && !r_ess_d;
  assign w_trig       = w_period_hit || req || w_ess_rise;

  // counts engine-on ticks and wraps to zero when the period is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_cnt <= 8'd0;
      r_ess_d      <= 1'b0;
    end else begin
      r_ess_d <= ess_trigger;
      if (tick_1sec && engine_on) begin
        if (w_period_hit) r_period_cnt <= 8'd0;
        else              r_period_cnt <= w_cnt_inc;
      end
    end
  end

  // state register, byte index, pending follow-up flag and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= 4'd0;
      r_pending     <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)
        r_idx <= 4'd0;
      else if (w_accept && !w_last)
        r_idx <= r_idx + 4'd1;
      // a trigger while sending (including the final byte) queues one more frame
      if (w_start)
        r_pending <= 1'b0;
      else if ((r_state == ST_SEND) && w_trig)
        r_pending <= 1'b1;
      if (w_last)
        r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // captures the frame contents in the cycle the frame starts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_speed  <= 8'd0;
      r_rpm    <= 14'd0;
      r_fuel   <= 8'd0;
      r_temp   <= 8'd0;
      r_odo    <= 32'd0;
      r_status <= 8'd0;
`ifdef OBD_SEQ_EN
      r_seq    <= 8'd0;
`endif
    end else if (w_start) begin
      r_speed  <= speed;
      r_rpm    <= rpm;
      r_fuel   <= fuel;
      r_temp   <= temp;
      r_odo    <= odometer_raw;
      r_status <= {engine_on, ess_trigger, 2'b00, current_gear};
`ifdef OBD_SEQ_EN
      r_seq    <= r_frame_count[7:0];
`endif
    end
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    tx_valid    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig || r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) begin
          w_accept = 1'b1;
          if (r_idx == c_last) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // frame byte map built from the snapshot, checksum covers LEN..STATUS
  always_comb begin
    for (int i = 0; i < 16; i++) w_frame[i] = 8'h00;
    w_frame[0]         = HEADER;
    w_frame[1]         = c_len;
`ifdef OBD_SEQ_EN
    w_frame[2]         = r_seq;
`endif
    w_frame[c_off + 0] = r_speed;
    w_frame[c_off + 1] = {2'b00, r_rpm[13:8]};
    w_frame[c_off + 2] = r_rpm[7:0];
    w_frame[c_off + 3] = r_fuel;
    w_frame[c_off + 4] = r_temp;
    w_frame[c_off + 5] = r_odo[31:24];
    w_frame[c_off + 6] = r_odo[23:16];
    w_frame[c_off + 7] = r_odo[15:8];
    w_frame[c_off + 8] = r_odo[7:0];
    w_frame[c_off + 9] = r_status;
    w_chk = 8'h00;
    for (int i = 1; i < c_nbytes - 1; i++) w_chk = w_chk ^ w_frame[i];
    w_frame[c_nbytes - 1] = w_chk;
  end

  assign tx_data     = (r_state == ST_SEND) ? w_frame[r_idx] : 8'h00;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_obd_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_obd_frame_tx
//  Description : Directed self-checking bench for obd_frame_tx
//                (OBD_SEQ_EN selects the sequence-byte frame checks)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obd_frame_tx;

`ifdef OBD_SEQ_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        engine_on = 1'b0;
  logic        tick_1sec = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  speed = 8'h00;
  logic [13:0] rpm = 14'd0;
  logic [7:0]  fuel = 8'h00;
  logic [7:0]  temp = 8'h00;
  logic [31:0] odometer_raw = 32'd0;
  logic [3:0]  current_gear = 4'd0;
  logic        ess_trigger = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [15:0] frame_count;

  obd_frame_tx #(.PERIOD_TICKS(3), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .engine_on(engine_on), .tick_1sec(tick_1sec),
    .req(req), .speed(speed), .rpm(rpm), .fuel(fuel), .temp(temp),
    .odometer_raw(odometer_raw), .current_gear(current_gear),
    .ess_trigger(ess_trigger), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       ready;
    logic [7:0] speed;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  vec_t       tv [0:2*NB-1];
  logic [7:0] exp_base [0:15];
  logic [7:0] exp_s1   [0:15];
  logic [7:0] got      [0:15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    speed        = 8'h3C;
    rpm          = 14'd2300;
    fuel         = 8'h64;
    temp         = 8'h28;
    odometer_raw = 32'h0000_0123;
    current_gear = 4'd12;
    engine_on    = 1'b1;
    ess_trigger  = 1'b0;
  endtask

  // waits (bounded) for tx_valid, then accepts a whole frame with tx_ready=1
  task automatic recv_frame(input int budget, output int gap);
    gap      = 0;
    tx_ready = 1'b1;
    while (!tx_valid && gap < budget) begin
      step();
      gap++;
    end
    check("frame_start_valid", tx_valid, 1);
    for (int i = 0; i < NB; i++) begin
      check("frame_byte_valid", tx_valid, 1);
      got[i] = tx_data;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          gap;
    int          vcount;
    logic [15:0] fc0;

`ifdef OBD_SEQ_EN
    exp_base = '{8'hA5, 8'h0B, 8'h00, 8'h3C, 8'h08, 8'hFC, 8'h64, 8'h28,
                 8'h00, 8'h00, 8'h01, 8'h23, 8'h8C, 8'h21, 8'h00, 8'h00};
    exp_s1   = '{8'hA5, 8'h0B, 8'h01, 8'h3C, 8'h08, 8'hFC, 8'h64, 8'h28,
                 8'h00, 8'h00, 8'h01, 8'h23, 8'h8C, 8'h20, 8'h00, 8'h00};
`else
    exp_base = '{8'hA5, 8'h0A, 8'h3C, 8'h08, 8'hFC, 8'h64, 8'h28, 8'h00,
                 8'h00, 8'h01, 8'h23, 8'h8C, 8'h20, 8'h00, 8'h00, 8'h00};
    exp_s1   = exp_base;
`endif
    // stalled-transmitter vectors: each byte shown twice, accepted on the second
    for (int j = 0; j < 2*NB; j++) begin
      tv[j].ready = (j % 2 == 1);
      tv[j].speed = (j >= 8) ? 8'h50 : 8'h3C;
      tv[j].valid = 1'b1;
      tv[j].data  = exp_base[j/2];
    end

    // reset state
    rst = 1'b1;
    step();
    step();
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_tx_data", tx_data, 0);
    rst = 1'b0;
    set_defaults();
    tx_ready = 1'b1;
    step();
    check("idle_no_trigger_busy", busy, 0);

`ifdef OBD_SEQ_EN
    // two requested frames carry sequence bytes 0 and 1
    req = 1'b1;
    step();
    req = 1'b0;
    recv_frame(4, gap);
    for (int i = 0; i < NB; i++) check("seq_frame0_byte", got[i], exp_base[i]);
    req = 1'b1;
    step();
    req = 1'b0;
    recv_frame(4, gap);
    for (int i = 0; i < NB; i++) check("seq_frame1_byte", got[i], exp_s1[i]);
    check("seq_frame_count", frame_count, 2);
`else
    // test 1: request, header next cycle, 13 consecutive bytes
    req = 1'b1;
    step();
    req = 1'b0;
    check("t1_latency_valid", tx_valid, 1);
    check("t1_busy", busy, 1);
    for (int i = 0; i < NB; i++) begin
      check("t1_byte_valid", tx_valid, 1);
      check("t1_byte", tx_data, exp_base[i]);
      step();
    end
    check("t1_frame_count", frame_count, 1);
    check("t1_idle_after", tx_valid, 0);

    // test 2: tx_ready toggling, speed changed mid-frame
    req      = 1'b1;
    tx_ready = 1'b0;
    step();
    req = 1'b0;
    for (int j = 0; j < 2*NB; j++) begin
      speed    = tv[j].speed;
      tx_ready = tv[j].ready;
      check("t2_valid", tx_valid, tv[j].valid);
      check("t2_byte", tx_data, tv[j].data);
      step();
    end
    check("t2_frame_count", frame_count, 2);
    check("t2_idle_after", tx_valid, 0);
    speed    = 8'h3C;
    tx_ready = 1'b1;

    // test 3: periodic frames every 3 engine-on ticks
    fc0 = frame_count;
    for (int t = 0; t < 7; t++) begin
      tick_1sec = 1'b1;
      step();
      tick_1sec = 1'b0;
      for (int c = 0; c < 20; c++) step();
    end
    check("t3_periodic_frames", 16'(frame_count - fc0), 2);
    engine_on = 1'b0;
    fc0 = frame_count;
    for (int t = 0; t < 5; t++) begin
      tick_1sec = 1'b1;
      step();
      tick_1sec = 1'b0;
      for (int c = 0; c < 20; c++) step();
    end
    check("t3_engine_off_frames", 16'(frame_count - fc0), 0);
    req = 1'b1;
    step();
    req = 1'b0;
    recv_frame(4, gap);
    check("t3_req_gap", gap, 0);
    check("t3_status_engine_off", got[11], 8'h0C);
    check("t3_chk_engine_off", got[12], 8'hA0);
    check("t3_busy_after", busy, 0);
    engine_on = 1'b1;

    // test 4: ESS edge at idx 5 plus a req in the same frame -> one follow-up
    fc0 = frame_count;
    req = 1'b1;
    step();
    for (int i = 0; i < NB; i++) begin
      req = (i == 8);
      if (i == 5) ess_trigger = 1'b1;
      check("t4_first_byte", tx_data, exp_base[i]);
      step();
    end
    req = 1'b0;
    recv_frame(5, gap);
    check("t4_gap", gap, 1);
    check("t4_speed", got[2], 8'h3C);
    check("t4_status_ess", got[11], 8'hCC);
    check("t4_chk_ess", got[12], 8'h60);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid) vcount++;
      step();
    end
    check("t4_no_more_frames", vcount, 0);
    check("t4_frame_delta", 16'(frame_count - fc0), 2);

    // test 5: reset mid-frame aborts it, later req sends a full frame
    ess_trigger = 1'b0;
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t5_at_idx7", tx_data, exp_base[7]);
    rst = 1'b1;
    step();
    check("t5_rst_valid", tx_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_frame_count", frame_count, 0);
    rst = 1'b0;
    step();
    step();
    check("t5_no_resume", tx_valid, 0);
    req = 1'b1;
    step();
    req = 1'b0;
    recv_frame(4, gap);
    check("t5_gap", gap, 0);
    for (int i = 0; i < NB; i++) check("t5_byte", got[i], exp_base[i]);
    check("t5_frame_count", frame_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obd_frame_tx.md
Name: obd_frame_tx

Overview:
- Consumer end of the vehicle-state interface: snapshots speed, rpm, fuel, temp, odometer, gear and ESS status.
- Serialises the snapshot into a fixed telemetry frame and streams it one byte at a time over a valid/ready handshake into the downstream UART byte transmitter.
- Frames are sent periodically on tick_1sec, on an explicit request, or immediately on an ESS (emergency stop) rising edge.

Parameters:
- PERIOD_TICKS, 1: number of counted tick_1sec pulses between periodic frames (range 1..255).
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- engine_on  input  1  engine running; gates periodic frames only
- tick_1sec  input  1  one-cycle 1 Hz strobe
- req  input  1  one-cycle manual frame request
- speed  input  8  km/h
- rpm  input  14  engine rpm
- fuel  input  8  fuel level
- temp  input  8  coolant temperature
- odometer_raw  input  32  odometer accumulator
- current_gear  input  4  3:P, 6:R, 9:N, 12:D
- ess_trigger  input  1  emergency-stop flag (level)
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts byte
- busy  output  1  frame in progress
- frame_count  output  16  frames fully sent, wraps at 0xFFFF->0

Behaviour:
- Frame, 13 bytes:
  - HEADER
  - LEN=0x0A
  - speed
  - {2'b00, rpm[13:8]}
  - rpm[7:0]
  - fuel
  - temp
  - odo[31:24], odo[23:16], odo[15:8], odo[7:0]
  - STATUS={engine_on, ess_trigger, 2'b00, current_gear}
  - CHK = XOR of LEN through STATUS (HEADER excluded)
- Snapshot: all data inputs are registered in the cycle the frame starts. Input changes during a frame do not affect it.
- Triggers:
  - Periodic: tick_1sec with engine_on increments period counter; when the counter reaches PERIOD_TICKS it clears to 0 and raises a trigger. tick_1sec with engine_on=0 is ignored and the counter holds.
  - req=1.
  - ess_trigger rising edge (previous-cycle register, reset 0).
- FSM:
  - IDLE: any trigger this cycle, or pending=1 -> take snapshot, idx<=0, go SEND, clear pending.
  - SEND: tx_valid=1, tx_data=byte[idx]. On tx_valid&tx_ready: if idx==12 go IDLE and frame_count+=1, else idx+=1.
- Latency: trigger in cycle k (IDLE, pending=0) -> header presented with tx_valid=1 in cycle k+1. With tx_ready held 1, a frame occupies 13 consecutive cycles. Back-to-back frames have exactly one IDLE cycle between them.
- Handshake:
  - While tx_valid=1 and tx_ready=0, tx_data and idx hold.
  - tx_valid never drops mid-frame.
  - tx_ready while tx_valid=0 is ignored.
- Triggers while busy set pending (single bit). Multiple triggers coalesce into one follow-up frame, whose snapshot is taken when it starts. Triggers in the final-byte cycle also set pending.
- busy=1 in SEND, 0 in IDLE.
- Simultaneous triggers in one cycle yield one frame.
- Reset values (synchronous; rst mid-frame aborts it):
  - tx_valid=0, tx_data=0, busy=0, frame_count=0
  - pending=0, period counter=0, idx=0, ESS edge register=0, state IDLE
- The aborted frame is not counted and no resume occurs.

Optional Feature:
- OBD_SEQ_EN defined:
  - An 8-bit sequence byte is inserted after LEN; LEN=0x0B and the frame is 14 bytes.
  - The sequence byte equals frame_count[7:0] at frame start and is included in CHK.
- Undefined: 13-byte frame as above, no sequence logic.

Test Plan:
1. rst, then req pulse with speed=0x3C, rpm=2300, fuel=0x64, temp=0x28, odo=0x123, gear=12, engine_on=1, ess=0, tx_ready=1 -> header in next cycle, then bytes A5 0A 3C 08 FC 64 28 00 00 01 23 8C 20 on 13 consecutive cycles; frame_count=1.
2. Same frame with tx_ready toggling 1/0 every cycle, and speed changed to 0x50 mid-frame -> identical byte sequence, each byte held stable while tx_ready=0, speed byte still 0x3C.
3. PERIOD_TICKS=3 with engine_on=1 and 7 tick_1sec pulses -> exactly 2 frames; engine_on=0 with ticks -> no frames; req with engine_on=0 -> one frame with STATUS bit7=0.
4. ess_trigger 0->1 while a frame is at idx 5, plus a req in the same frame -> one follow-up frame starting 1 cycle after CHK, STATUS=0xCC (gear 12, ess=1); no further frames while ess stays 1.
5. rst asserted at idx 7 -> tx_valid=0, busy=0, frame_count=0 next cycle; a later req produces a full frame starting at HEADER.
6. OBD_SEQ_EN defined: two req frames -> second frame bytes A5 0B 01 ..., 14 bytes, CHK includes the sequence byte.
